// File: rtl/program_launcher.sv
// program_launcher: initiator side of the core run handshake.
// A host go pulse holds req high for REQ_CYCLES clocks, then the block counts
// RUN cycles until the core signals a qualified ack (DONE) or the count reaches
// TIMEOUT_CYCLES (TIMEOUT). The result is held until the next go or abort.
module program_launcher #(
    parameter int REQ_CYCLES     = 2,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             go,
    input  logic             abort,
    input  logic             ack,
    output logic             req,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int RC_W = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;
    localparam logic [RC_W-1:0]  REQ_LAST    = RC_W'(REQ_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t           state, state_next;
    logic [RC_W-1:0]  req_cnt, req_cnt_next;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] count_inc;
    logic             ack_armed, ack_armed_next;

    // Next-state, launch counter, run counter and ack qualification.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_next     = state;
        req_cnt_next   = req_cnt;
        count_next     = cycle_count;
        ack_armed_next = ack_armed;
        // Saturating increment; the counter never wraps back to zero.
        count_inc      = (cycle_count == '1) ? cycle_count : cycle_count + CNT_W'(1);

        if (abort) begin
            // Cancel wins over go and ack; the count is left as it stood.
            state_next = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (go) begin
                        state_next     = S_LAUNCH;
                        count_next     = '0;
                        req_cnt_next   = '0;
                        ack_armed_next = 1'b0;
                    end
                end
                S_LAUNCH: begin
                    // ack is not looked at here; the core is still being started.
                    if (req_cnt == REQ_LAST) begin
                        state_next = S_RUN;
                    end else begin
                        req_cnt_next = req_cnt + RC_W'(1);
                    end
                end
                S_RUN: begin
                    count_next = count_inc;
                    // An ack already high when RUN starts is left over from the
                    // previous program; only an ack seen low first is trusted.
                    if (!ack) begin
                        ack_armed_next = 1'b1;
                    end
                    if (ack && ack_armed) begin
                        state_next = S_DONE;
                    end else if (count_inc == TIMEOUT_VAL) begin
                        state_next = S_TIMEOUT;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // State, internal counters and registered outputs decoded from next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            req_cnt     <= '0;
            ack_armed   <= 1'b0;
            cycle_count <= '0;
            req         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timed_out   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state       <= state_next;
            req_cnt     <= req_cnt_next;
            ack_armed   <= ack_armed_next;
            cycle_count <= count_next;
            req         <= (state_next == S_LAUNCH);
            busy        <= (state_next == S_LAUNCH) || (state_next == S_RUN);
            done        <= (state_next == S_DONE);
            timed_out   <= (state_next == S_TIMEOUT);
        end
    end

endmodule

// File: tb/tb_program_launcher.sv
// Directed bench for program_launcher with a short timeout so the timeout
// path is reachable; expected values are worked out by hand per scenario.
module tb_program_launcher;

    localparam int CNT_W = 16;

    logic             clock = 1'b0;
    logic             reset_n;
    logic             go;
    logic             abort;
    logic             ack;
    logic             req;
    logic             busy;
    logic             done;
    logic             timed_out;
    logic [CNT_W-1:0] cycle_count;

    int n_cmp = 0;
    int n_err = 0;

    program_launcher #(
        .REQ_CYCLES     (2),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .go          (go),
        .abort       (abort),
        .ack         (ack),
        .req         (req),
        .busy        (busy),
        .done        (done),
        .timed_out   (timed_out),
        .cycle_count (cycle_count)
    );

    always #5 clock = ~clock;

    // Hard stop in case a scenario goes wrong and the run would not end.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to end earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    task automatic check_status(input string tag, input logic e_req, input logic e_busy,
                                input logic e_done, input logic e_to, input int e_cnt);
        check({tag, ".req"},   32'(req),         32'(e_req));
        check({tag, ".busy"},  32'(busy),        32'(e_busy));
        check({tag, ".done"},  32'(done),        32'(e_done));
        check({tag, ".to"},    32'(timed_out),   32'(e_to));
        check({tag, ".count"}, 32'(cycle_count), 32'(e_cnt));
    endtask

    // One clock edge, then settle away from the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // go pulse; req must be high for exactly two edges. Returns in RUN cycle 1.
    task automatic launch(input string tag, input logic hold_go);
        go = 1'b1;
        tick();
        go = hold_go;
        check_status({tag, ".l1"}, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        tick();
        check({tag, ".l2.req"}, 32'(req), 32'd1);
        tick();
        go = 1'b0;
        check_status({tag, ".r1"}, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    endtask

    task automatic run_idle(input int n);
        for (int k = 0; k < n; k++) begin
            ack = 1'b0;
            tick();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        go      = 1'b0;
        abort   = 1'b0;
        ack     = 1'b0;
        #2;
        check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        #10 reset_n = 1'b1;
        tick();
        check_status("idle", 1'b0, 1'b0, 1'b0, 1'b0, 0);

        // 1: ack arrives on RUN cycle 35.
        launch("t1", 1'b0);
        run_idle(34);
        check_status("t1.c34", 1'b0, 1'b1, 1'b0, 1'b0, 34);
        ack = 1'b1;
        tick();
        check_status("t1.done", 1'b0, 1'b0, 1'b1, 1'b0, 35);
        ack = 1'b0;
        tick();
        check_status("t1.hold", 1'b0, 1'b0, 1'b1, 1'b0, 35);

        // 2: stale ack through LAUNCH and RUN cycle 1, real ack on cycle 10.
        ack = 1'b1;
        launch("t2", 1'b0);
        tick();
        check_status("t2.stale", 1'b0, 1'b1, 1'b0, 1'b0, 1);
        run_idle(8);
        check_status("t2.c9", 1'b0, 1'b1, 1'b0, 1'b0, 9);
        ack = 1'b1;
        tick();
        check_status("t2.done", 1'b0, 1'b0, 1'b1, 1'b0, 10);
        ack = 1'b0;

        // 3: no ack, timeout after 100 RUN cycles.
        launch("t3", 1'b0);
        run_idle(99);
        check_status("t3.c99", 1'b0, 1'b1, 1'b0, 1'b0, 99);
        tick();
        check_status("t3.to", 1'b0, 1'b0, 1'b0, 1'b1, 100);
        tick();
        check_status("t3.frozen", 1'b0, 1'b0, 1'b0, 1'b1, 100);

        // 4: abort after five counted RUN cycles.
        launch("t4", 1'b0);
        run_idle(5);
        check_status("t4.c5", 1'b0, 1'b1, 1'b0, 1'b0, 5);
        abort = 1'b1;
        ack   = 1'b1;
        tick();
        abort = 1'b0;
        ack   = 1'b0;
        check_status("t4.abort", 1'b0, 1'b0, 1'b0, 1'b0, 5);
        tick();
        check_status("t4.idle", 1'b0, 1'b0, 1'b0, 1'b0, 5);

        // 5: go held through LAUNCH and pulsed in RUN is ignored.
        launch("t5", 1'b1);
        run_idle(2);
        go = 1'b1;
        tick();
        go = 1'b0;
        check_status("t5.c3", 1'b0, 1'b1, 1'b0, 1'b0, 3);
        run_idle(16);
        check_status("t5.c19", 1'b0, 1'b1, 1'b0, 1'b0, 19);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_status("t5.done1", 1'b0, 1'b0, 1'b1, 1'b0, 20);
        launch("t5b", 1'b0);
        run_idle(6);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_status("t5.done2", 1'b0, 1'b0, 1'b1, 1'b0, 7);
        // abort beats a simultaneous go.
        go    = 1'b1;
        abort = 1'b1;
        tick();
        go    = 1'b0;
        abort = 1'b0;
        check_status("t5.prio", 1'b0, 1'b0, 1'b0, 1'b0, 7);

        // 6: asynchronous reset in the middle of LAUNCH.
        go = 1'b1;
        tick();
        go = 1'b0;
        check({"t6.pre.req"}, 32'(req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_status("t6.async", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        #2 reset_n = 1'b1;
        tick();
        check_status("t6.idle", 1'b0, 1'b0, 1'b0, 1'b0, 0);
        launch("t6", 1'b0);
        run_idle(34);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check_status("t6.done", 1'b0, 1'b0, 1'b1, 1'b0, 35);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
